// File: rtl/ram16x8_pkg.sv
// Shared widths, beat limit and FSM state type for the 16x8 RAM master.
// Latency: n/a. Backpressure: n/a.
package ram16x8_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = $clog2(MAX_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_LAST
`ifdef RAM_MASTER_TURNAROUND_EN
    ,
    TURN
`endif
  } state_t;

endpackage

// File: rtl/ram16x8_addr_ctr.sv
// Burst address/beat counter: loads a start address and beat count, steps with wrap.
// Latency: addr/last update one cycle after load or inc. Backpressure: none, inc is a command.
module ram16x8_addr_ctr
  import ram16x8_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [AW-1:0]    load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [AW-1:0]    addr,
  output logic             last
);

  logic [LEN_W-1:0] remaining;

  // addr is AW bits wide, so the increment wraps modulo 2^AW for free
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (inc) begin
      addr      <= addr + AW'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/ram_16x8_master.sv
// Single-write / burst-read master for a 16x8 RAM on a shared tri-state data bus.
// Latency: write op_done at E0+2, read beat i at E0+3+i. Backpressure: req_ready only in IDLE, rsp has none.
// Build option RAM_MASTER_TURNAROUND_EN inserts one TURN cycle after every transaction.
module ram_16x8_master
  import ram16x8_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          op_done,
  output logic [AW-1:0] mem_ad,
  output logic          mem_cs,
  output logic          mem_w_en,
  output logic          mem_op_en,
  inout  wire  [DW-1:0] mem_data
);

  state_t        state;
  logic          drive_q;
  logic [DW-1:0] wdata_q;
  logic          accept;
  logic          ctr_inc;
  logic          ctr_last;
  logic [3:0]    ctr_len;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign ctr_inc   = (state == RD_ADDR) & ~ctr_last;
  assign ctr_len   = req_write ? 4'd0 : req_len;

  // the counter's address register is the registered mem_ad
  ram16x8_addr_ctr #(.AW(AW)) u_addr_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .inc       (ctr_inc),
    .load_addr (req_addr),
    .load_len  (ctr_len),
    .addr      (mem_ad),
    .last      (ctr_last)
  );

  assign mem_data = drive_q ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drive_q   <= 1'b0;
      wdata_q   <= '0;
      mem_cs    <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_op_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      op_done   <= 1'b0;
    end else begin
      op_done   <= 1'b0;
      // every output-enable cycle returns exactly one beat on the next cycle
      rsp_valid <= mem_op_en;
      if (mem_op_en) rsp_rdata <= mem_data;

      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_cs <= 1'b1;
            if (req_write) begin
              state    <= WRITE;
              mem_w_en <= 1'b1;
              drive_q  <= 1'b1;
              wdata_q  <= req_wdata;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          mem_cs   <= 1'b0;
          mem_w_en <= 1'b0;
          drive_q  <= 1'b0;
`ifdef RAM_MASTER_TURNAROUND_EN
          state    <= TURN;
`else
          state    <= IDLE;
          op_done  <= 1'b1;
`endif
        end
        RD_ADDR: begin
          mem_op_en <= 1'b1;
          if (ctr_last) state <= RD_LAST;
        end
        RD_LAST: begin
          mem_cs    <= 1'b0;
          mem_op_en <= 1'b0;
`ifdef RAM_MASTER_TURNAROUND_EN
          state     <= TURN;
`else
          state     <= IDLE;
          op_done   <= 1'b1;
`endif
        end
`ifdef RAM_MASTER_TURNAROUND_EN
        TURN: begin
          state   <= IDLE;
          op_done <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_16x8_master.sv
// Randomised scoreboard bench for ram_16x8_master with a behavioural RAM on the shared bus.
module tb_ram_16x8_master;

`ifdef RAM_MASTER_TURNAROUND_EN
  localparam int TURN_CYC = 1;
`else
  localparam int TURN_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       op_done;
  logic [3:0] mem_ad;
  logic       mem_cs, mem_w_en, mem_op_en;
  wire  [7:0] mem_data;

  ram_16x8_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .op_done(op_done),
    .mem_ad(mem_ad), .mem_cs(mem_cs), .mem_w_en(mem_w_en), .mem_op_en(mem_op_en),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: latches the address each selected cycle, drives the bus when output-enabled
  logic [7:0] ram [16];
  logic [3:0] ram_rd_q;
  always @(posedge clk) begin
    if (mem_cs) begin
      ram_rd_q <= mem_ad;
      if (mem_w_en) ram[mem_ad] <= mem_data;
    end
  end
  assign mem_data = (mem_cs && mem_op_en && !mem_w_en) ? ram[ram_rd_q] : 8'bz;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       rsp_q[$];
  int         done_q[$];
  logic [7:0] ref_mem [16];
  int         compared = 0;
  int         mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_data", rsp_rdata, e.data);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
    if (op_done) begin
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
      end
    end
    if (mem_w_en) chk("wen_with_open", mem_op_en, 0);
    if (req_ready) chk("idle_cs", mem_cs, 0);
  end

  // issues one request; e0 is the label of the acceptance cycle (next cycle is E0+1)
  task automatic issue(input bit wr, input logic [3:0] a, input logic [3:0] len,
                       input logic [7:0] d, output int e0);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      e0 = -1;
      return;
    end
    e0 = cyc;
    if (wr) begin
      ref_mem[a] = d;
      done_q.push_back(e0 + 2 + TURN_CYC);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        exp_t e;
        logic [3:0] ai;
        ai = 4'((int'(a) + i) % 16);
        e.data = ref_mem[ai];
        e.cyc  = e0 + 3 + i;
        rsp_q.push_back(e);
      end
      done_q.push_back(e0 + int'(len) + 3 + TURN_CYC);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    int e0, e1, n;

    // request presented while reset is held must be ignored
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd9;
    req_wdata = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("rst_cs", mem_cs, 0);
      chk("rst_done", op_done, 0);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_mem_op_en", mem_op_en, 0);
    chk("rst_mem_ad", mem_ad, 0);

    // fill every word, then read the whole array in one burst
    for (int k = 0; k < 16; k++) issue(1'b1, 4'(k), 4'd0, 8'(8'h10 + k), e0);
    issue(1'b0, 4'd0, 4'd15, 8'h00, e0);

    // single write / single read
    issue(1'b1, 4'd3, 4'd0, 8'hA5, e0);
    issue(1'b0, 4'd3, 4'd0, 8'h00, e0);

    // burst wrapping past the top address
    issue(1'b0, 4'd14, 4'd3, 8'h00, e0);

    // write then read back-to-back: idle gap depends on turnaround option
    issue(1'b1, 4'd6, 4'd0, 8'h5C, e0);
    issue(1'b0, 4'd6, 4'd0, 8'h00, e1);
    chk("b2b_gap", e1 - e0, 2 + TURN_CYC);

    // reset during beat 2 of an 8-beat read
    issue(1'b0, 4'd5, 4'd7, 8'h00, e0);
    n = 0;
    while (cyc < e0 + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    reset = 1'b1;
    rsp_q.delete();
    done_q.delete();
    @(negedge clk);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 0);
    chk("mid_rst_op_done", op_done, 0);
    chk("mid_rst_mem_cs", mem_cs, 0);
    chk("mid_rst_mem_op_en", mem_op_en, 0);
    chk("mid_rst_mem_ad", mem_ad, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    // randomised mix of writes and bursts
    for (int t = 0; t < 40; t++) begin
      int gap;
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), e0);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    n = 0;
    while ((rsp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp", rsp_q.size(), 0);
    chk("drain_done", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_16x8_master.md
RAM_16X8_MASTER -- requirements
Module: ram_16x8_master

Interface
REQ-001 SHALL have parameter AW, default 4, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted on edge with req_valid.
REQ-007 SHALL have port req_write  input  1  1=single write, 0=read burst.
REQ-008 SHALL have port req_addr  input  AW  start address.
REQ-009 SHALL have port req_len  input  4  read beats minus one; ignored for writes.
REQ-010 SHALL have port req_wdata  input  DW  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse per read beat.
REQ-012 SHALL have port rsp_rdata  output  DW  read beat data.
REQ-013 SHALL have port op_done  output  1  one-cycle pulse when a transaction ends.
REQ-014 SHALL have ports mem_ad (output, AW), mem_cs, mem_w_en, mem_op_en (output, 1): RAM-side controls, all registered.
REQ-015 SHALL have port mem_data  inout  DW  shared RAM data bus.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, RD_ADDR, RD_LAST, plus TURN when configured.
REQ-017 SHALL assert req_ready only in IDLE; acceptance = req_valid & req_ready at edge E0.
REQ-018 SHALL, for a write, spend exactly one cycle (E0+1) in WRITE: mem_cs=1, mem_w_en=1, mem_op_en=0, mem_ad=req_addr, mem_data=req_wdata; then IDLE (or TURN), op_done high in cycle E0+2.
REQ-019 SHALL, for a read of N=req_len+1 beats, issue addresses A, A+1, ... A+N-1 in cycles E0+1..E0+N with mem_cs=1, mem_w_en=0; mem_op_en=0 in cycle E0+1, 1 thereafter.
REQ-020 SHALL hold cycle E0+N+1 in RD_LAST: mem_cs=1, mem_w_en=0, mem_op_en=1, mem_ad unchanged.
REQ-021 SHALL register mem_data at the end of each op_en cycle; beat i presented as rsp_rdata with rsp_valid=1 in cycle E0+3+i.
REQ-022 SHALL pulse op_done in the cycle of the last rsp_valid; return to IDLE (req_ready=1) in that same cycle.
REQ-023 SHALL increment address modulo 2^AW (15 wraps to 0); req_len=15 from address 0 reads all 16 words once.
REQ-024 SHALL drive mem_data only in WRITE; hi-Z in every other state and during reset.
REQ-025 SHALL never assert mem_w_en and mem_op_en together; mem_cs=0 in IDLE and TURN.
REQ-026 SHALL provide no response backpressure; rsp_valid is not held.

Reset
REQ-027 SHALL, on reset high at an edge, enter IDLE: req_ready=1, rsp_valid=0, rsp_rdata=0, op_done=0, mem_cs=0, mem_w_en=0, mem_op_en=0, mem_ad=0, mem_data hi-Z.
REQ-028 SHALL discard any in-flight transaction on mid-operation reset: no further rsp_valid or op_done for it.
REQ-029 SHALL ignore req_valid while reset is high.

Configuration
REQ-030 SHALL, with RAM_MASTER_TURNAROUND_EN defined, enter TURN for one cycle after WRITE and after RD_LAST (req_ready=0, mem_cs=0, bus hi-Z), delaying op_done and req_ready by one cycle.
REQ-031 SHALL, without RAM_MASTER_TURNAROUND_EN, permit back-to-back transactions with no idle cycle.

Structure
REQ-032 SHALL place AW/DW defaults, state enum and MAX_BEATS=16 in package ram16x8_pkg.
REQ-033 SHALL implement address/beat counting in sub-module ram16x8_addr_ctr (load, increment, wrap, last-beat flag).

Verification
REQ-034 Write 0xA5 to addr 3, then read len 0 from 3 -> single rsp_valid, rsp_rdata=0xA5, op_done coincident.
REQ-035 Write addr k with 0x10+k for k=0..15, read len 15 from 0 -> 16 consecutive rsp_valid, data 0x10..0x1F, first at E0+3.
REQ-036 Read len 3 from addr 14 -> data from addresses 14, 15, 0, 1 in order.
REQ-037 Assert reset during beat 2 of a len-7 read -> outputs at reset values next cycle, no further rsp_valid, req_ready=1.
REQ-038 Write then read back-to-back, with and without RAM_MASTER_TURNAROUND_EN -> zero vs one idle cycle; mem_data never driven while mem_op_en=1.
